// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl: miniRV five-stage hazard controller (stall, flush, forward).  |
// | Optional counters: define HAZARD_PERF_EN.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter logic [2:0] WB_SEL_LOAD = 3'd1,
    parameter int         CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_wR_i,
    input  logic             ex_rf_we_i,
    input  logic [2:0]       ex_wb_sel_i,
    input  logic             ex_null_i,
    input  logic [4:0]       mem_wR_i,
    input  logic             mem_rf_we_i,
    input  logic             mem_null_i,
    input  logic [4:0]       wb_wR_i,
    input  logic             wb_rf_we_i,
    input  logic             wb_null_i,
    input  logic             br_taken_i,
    input  logic             ext_stall_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_null_o,
    output logic             pipe_freeze_o,
    output logic [1:0]       fwd1_sel_o,
    output logic [1:0]       fwd2_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_FROZEN   = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    state_t state_q, state_d;

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic ex_is_load, load_use;
    logic [1:0] fwd1_raw, fwd2_raw;

    function automatic logic stage_match(
        input logic       used,
        input logic       we,
        input logic       nul,
        input logic [4:0] wr,
        input logic [4:0] rs
    );
        return used && we && !nul && (wr == rs) && (rs != 5'd0);
    endfunction

    function automatic logic [1:0] pick_fwd(
        input logic ex_m,
        input logic mem_m,
        input logic wb_m,
        input logic is_load
    );
        // A loaded value is not available in EX yet; older stages would be stale.
        if (ex_m)       return is_load ? FWD_RF : FWD_EX;
        else if (mem_m) return FWD_MEM;
        else if (wb_m)  return FWD_WB;
        else            return FWD_RF;
    endfunction

    always_comb begin
        ex_m1      = stage_match(id_rs1_used_i, ex_rf_we_i,  ex_null_i,  ex_wR_i,  id_rs1_i);
        ex_m2      = stage_match(id_rs2_used_i, ex_rf_we_i,  ex_null_i,  ex_wR_i,  id_rs2_i);
        mem_m1     = stage_match(id_rs1_used_i, mem_rf_we_i, mem_null_i, mem_wR_i, id_rs1_i);
        mem_m2     = stage_match(id_rs2_used_i, mem_rf_we_i, mem_null_i, mem_wR_i, id_rs2_i);
        wb_m1      = stage_match(id_rs1_used_i, wb_rf_we_i,  wb_null_i,  wb_wR_i,  id_rs1_i);
        wb_m2      = stage_match(id_rs2_used_i, wb_rf_we_i,  wb_null_i,  wb_wR_i,  id_rs2_i);
        ex_is_load = (ex_wb_sel_i == WB_SEL_LOAD);
        load_use   = (ex_m1 || ex_m2) && ex_is_load;
        fwd1_raw   = pick_fwd(ex_m1, mem_m1, wb_m1, ex_is_load);
        fwd2_raw   = pick_fwd(ex_m2, mem_m2, wb_m2, ex_is_load);
    end

    always_comb begin
        state_d       = ST_RUN;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_null_o  = 1'b0;
        pipe_freeze_o = 1'b0;
        fwd1_sel_o    = FWD_RF;
        fwd2_sel_o    = FWD_RF;
        if (rst_i) begin
            state_d = ST_RUN;
        end else if (ext_stall_i) begin
            state_d       = ST_FROZEN;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            pipe_freeze_o = 1'b1;
        end else if (br_taken_i) begin
            state_d       = ST_FLUSH;
            if_id_flush_o = 1'b1;
            id_ex_null_o  = 1'b1;
            fwd1_sel_o    = fwd1_raw;
            fwd2_sel_o    = fwd2_raw;
        end else if (load_use) begin
            state_d       = ST_LU_STALL;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_null_o  = 1'b1;
        end else begin
            state_d    = ST_RUN;
            fwd1_sel_o = fwd1_raw;
            fwd2_sel_o = fwd2_raw;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    logic unused_state;
    assign unused_state = ^state_q;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Counted from the action taken this cycle, visible after the next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_d == ST_LU_STALL || state_d == ST_FROZEN)
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (state_d == ST_FLUSH)
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire
